// File: rtl/fila_escrita_pkg.sv
// -----------------------------------------------------------------------------
// pacote_hardcore
// Shared definitions for the dedup write-queue slice: default widths, the
// write-queue FSM state type and the packed queue entry layout.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pacote_hardcore;

    localparam int NUM_CLUSTERS = 8;
    localparam int TAM_HASH     = 8;
    localparam int TAM_ENDERECO = 64;
    localparam int TAM_CLUSTER  = $clog2(NUM_CLUSTERS);

    // OCIOSO: nothing in flight. ENVIA: a memory write is being presented.
    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ENVIA  = 1'b1
    } estado_t;

    // Entry layout with the default widths; the upper {cluster, hash} part is
    // exactly the memory write data.
    typedef struct packed {
        logic [TAM_CLUSTER-1:0]  cluster;
        logic [TAM_HASH-1:0]     hash;
        logic [TAM_ENDERECO-1:0] endereco;
    } entrada_t;

endpackage

// File: rtl/fila_escrita_memoria.sv
// -----------------------------------------------------------------------------
// memoria_fila
// PROFUNDIDADE x LARGURA register array for the write queue. One synchronous
// write port, one asynchronous read port. Contents are not reset: a slot is
// only ever read after it has been written.
// Ports:
//   clk          in   clock
//   escreve      in   write enable
//   end_escrita  in   write slot index
//   dado_escrita in   write data
//   end_leitura  in   read slot index
//   dado_leitura out  read data (combinational)
// -----------------------------------------------------------------------------
module memoria_fila #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 75
) (
    input  logic                            clk,
    input  logic                            escreve,
    input  logic [$clog2(PROFUNDIDADE)-1:0] end_escrita,
    input  logic [LARGURA-1:0]              dado_escrita,
    input  logic [$clog2(PROFUNDIDADE)-1:0] end_leitura,
    output logic [LARGURA-1:0]              dado_leitura
);

    logic [LARGURA-1:0] celulas [PROFUNDIDADE];

    // Write port: store the pushed entry into its slot.
    always_ff @(posedge clk) begin
        if (escreve) begin
            celulas[end_escrita] <= dado_escrita;
        end
    end

    assign dado_leitura = celulas[end_leitura];

endmodule

// File: rtl/fila_escrita.sv
// -----------------------------------------------------------------------------
// fila_escrita
// Write queue between the dedup core and memory. Buffers {endereco, hash,
// cluster} writes in FIFO order and presents them one at a time on a
// req/ack memory interface, back-to-back while entries remain.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   escrever       write request from the core
//   endereco       line address
//   hash           second-hash value
//   cluster        priority-encoded cluster index
//   trava          stall to the core (count >= PROFUNDIDADE-1), registered
//   mem_req        memory write request, held until mem_ack
//   mem_endereco   write address
//   mem_dado       write data {cluster, hash}
//   mem_ack        memory accepted the current request
//   erro_perda     sticky: a write was dropped because the queue was full
// Optional (macro FILA_ESCRITA_ESTATISTICAS_EN):
//   total_escritas number of mem_ack handshakes, wrapping
//   ciclos_trava   number of cycles with trava=1, saturating
// -----------------------------------------------------------------------------
module fila_escrita #(
    parameter int PROFUNDIDADE = 4,
    parameter int TAM_ENDERECO = pacote_hardcore::TAM_ENDERECO,
    parameter int TAM_HASH     = pacote_hardcore::TAM_HASH,
    parameter int NUM_CLUSTERS = pacote_hardcore::NUM_CLUSTERS
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     escrever,
    input  logic [TAM_ENDERECO-1:0]                  endereco,
    input  logic [TAM_HASH-1:0]                      hash,
    input  logic [$clog2(NUM_CLUSTERS)-1:0]          cluster,
    output logic                                     trava,
    output logic                                     mem_req,
    output logic [TAM_ENDERECO-1:0]                  mem_endereco,
    output logic [$clog2(NUM_CLUSTERS)+TAM_HASH-1:0] mem_dado,
    input  logic                                     mem_ack,
    output logic                                     erro_perda
`ifdef FILA_ESCRITA_ESTATISTICAS_EN
    ,
    output logic [31:0]                              total_escritas,
    output logic [31:0]                              ciclos_trava
`endif
);

    import pacote_hardcore::*;

    localparam int TAM_CLUST   = $clog2(NUM_CLUSTERS);
    localparam int TAM_DADO    = TAM_CLUST + TAM_HASH;
    localparam int TAM_ENTRADA = TAM_DADO + TAM_ENDERECO;
    localparam int TAM_PTR     = $clog2(PROFUNDIDADE);
    localparam int TAM_CONT    = TAM_PTR + 1;

    localparam logic [TAM_CONT-1:0] CONT_ZERO  = {TAM_CONT{1'b0}};
    localparam logic [TAM_CONT-1:0] CONT_UM    = TAM_CONT'(1);
    localparam logic [TAM_CONT-1:0] CONT_CHEIO = TAM_CONT'(PROFUNDIDADE);
    localparam logic [TAM_CONT-1:0] CONT_TRAVA = TAM_CONT'(PROFUNDIDADE - 1);
    localparam logic [TAM_PTR-1:0]  PTR_UM     = TAM_PTR'(1);

    estado_t                 estado_q, estado_d;
    logic [TAM_CONT-1:0]     cont_q, cont_d;
    logic [TAM_PTR-1:0]      ptr_esc_q, ptr_esc_d;
    logic [TAM_PTR-1:0]      ptr_lei_q, ptr_lei_d;
    logic                    mem_req_q, mem_req_d;
    logic [TAM_ENDERECO-1:0] mem_endereco_q, mem_endereco_d;
    logic [TAM_DADO-1:0]     mem_dado_q, mem_dado_d;
    logic                    trava_q, trava_d;
    logic                    erro_perda_q, erro_perda_d;

    logic                    grava_s;
    logic                    descarta_s;
    logic                    retira_s;
    logic                    carrega_s;
    logic [TAM_PTR-1:0]      end_leitura_s;
    logic [TAM_ENTRADA-1:0]  entrada_nova_s;
    logic [TAM_ENTRADA-1:0]  entrada_lida_s;

    assign entrada_nova_s = {cluster, hash, endereco};

    memoria_fila #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (TAM_ENTRADA)
    ) u_memoria (
        .clk          (clk),
        .escreve      (grava_s),
        .end_escrita  (ptr_esc_q),
        .dado_escrita (entrada_nova_s),
        .end_leitura  (end_leitura_s),
        .dado_leitura (entrada_lida_s)
    );

    // Push acceptance: decided on the count before the edge, so a pop at the
    // same edge never frees room for the push.
    always_comb begin
        grava_s    = 1'b0;
        descarta_s = 1'b0;
        if (escrever) begin
            if (cont_q < CONT_CHEIO) begin
                grava_s = 1'b1;
            end else begin
                descarta_s = 1'b1;
            end
        end else begin
            grava_s    = 1'b0;
            descarta_s = 1'b0;
        end
    end

    // FSM next state. The head stays in storage while it is being sent; it is
    // popped on mem_ack, and the next head (read one slot ahead) is loaded only
    // if entries older than this edge's push remain.
    always_comb begin
        estado_d      = estado_q;
        retira_s      = 1'b0;
        carrega_s     = 1'b0;
        end_leitura_s = ptr_lei_q;
        case (estado_q)
            OCIOSO: begin
                if (cont_q != CONT_ZERO) begin
                    carrega_s = 1'b1;
                    estado_d  = ENVIA;
                end else begin
                    estado_d  = OCIOSO;
                end
            end
            ENVIA: begin
                if (mem_ack) begin
                    retira_s      = 1'b1;
                    end_leitura_s = ptr_lei_q + PTR_UM;
                    if (cont_q > CONT_UM) begin
                        carrega_s = 1'b1;
                        estado_d  = ENVIA;
                    end else begin
                        estado_d  = OCIOSO;
                    end
                end else begin
                    estado_d = ENVIA;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // FSM outputs: load the memory-side registers or drop the request.
    always_comb begin
        mem_req_d      = mem_req_q;
        mem_endereco_d = mem_endereco_q;
        mem_dado_d     = mem_dado_q;
        if (carrega_s) begin
            mem_req_d      = 1'b1;
            mem_endereco_d = entrada_lida_s[TAM_ENDERECO-1:0];
            mem_dado_d     = entrada_lida_s[TAM_ENTRADA-1:TAM_ENDERECO];
        end else if (retira_s) begin
            mem_req_d = 1'b0;
        end else begin
            mem_req_d = mem_req_q;
        end
    end

    // Pointers, occupancy, stall and the sticky drop flag.
    always_comb begin
        ptr_esc_d = grava_s  ? (ptr_esc_q + PTR_UM) : ptr_esc_q;
        ptr_lei_d = retira_s ? (ptr_lei_q + PTR_UM) : ptr_lei_q;
        case ({grava_s, retira_s})
            2'b10:   cont_d = cont_q + CONT_UM;
            2'b01:   cont_d = cont_q - CONT_UM;
            default: cont_d = cont_q;
        endcase
        // Registered from the next count so trava has no input-to-output path.
        trava_d      = (cont_d >= CONT_TRAVA);
        erro_perda_d = erro_perda_q | descarta_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= OCIOSO;
            cont_q         <= CONT_ZERO;
            ptr_esc_q      <= {TAM_PTR{1'b0}};
            ptr_lei_q      <= {TAM_PTR{1'b0}};
            mem_req_q      <= 1'b0;
            mem_endereco_q <= {TAM_ENDERECO{1'b0}};
            mem_dado_q     <= {TAM_DADO{1'b0}};
            trava_q        <= 1'b0;
            erro_perda_q   <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cont_q         <= cont_d;
            ptr_esc_q      <= ptr_esc_d;
            ptr_lei_q      <= ptr_lei_d;
            mem_req_q      <= mem_req_d;
            mem_endereco_q <= mem_endereco_d;
            mem_dado_q     <= mem_dado_d;
            trava_q        <= trava_d;
            erro_perda_q   <= erro_perda_d;
        end
    end

    assign trava        = trava_q;
    assign mem_req      = mem_req_q;
    assign mem_endereco = mem_endereco_q;
    assign mem_dado     = mem_dado_q;
    assign erro_perda   = erro_perda_q;

`ifdef FILA_ESCRITA_ESTATISTICAS_EN
    logic [31:0] total_escritas_q, total_escritas_d;
    logic [31:0] ciclos_trava_q, ciclos_trava_d;

    // Statistics: handshakes wrap, stall cycles saturate.
    always_comb begin
        total_escritas_d = retira_s ? (total_escritas_q + 32'd1) : total_escritas_q;
        if (trava_q && (ciclos_trava_q != 32'hFFFF_FFFF)) begin
            ciclos_trava_d = ciclos_trava_q + 32'd1;
        end else begin
            ciclos_trava_d = ciclos_trava_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_escritas_q <= 32'd0;
            ciclos_trava_q   <= 32'd0;
        end else begin
            total_escritas_q <= total_escritas_d;
            ciclos_trava_q   <= ciclos_trava_d;
        end
    end

    assign total_escritas = total_escritas_q;
    assign ciclos_trava   = ciclos_trava_q;
`endif

endmodule

// File: doc/fila_escrita.md
FILA_ESCRITA -- requirements
Module: fila_escrita

Interface
REQ-001 SHALL have parameter PROFUNDIDADE, default 4: queue entries; power of two, at least 2.
REQ-002 SHALL have parameter TAM_ENDERECO, default 64: address width.
REQ-003 SHALL have parameter TAM_HASH, default 8: hash width.
REQ-004 SHALL have parameter NUM_CLUSTERS, default 8: cluster count; cluster index width is log2(NUM_CLUSTERS), 3 by default.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port escrever  input  1  write request from the dedup core ("escrever na memoria" event).
REQ-008 SHALL have port endereco  input  TAM_ENDERECO  line address to write.
REQ-009 SHALL have port hash  input  TAM_HASH  second-hash value of the line.
REQ-010 SHALL have port cluster  input  log2(NUM_CLUSTERS)  priority-encoded cluster index.
REQ-011 SHALL have port trava  output  1  stall to the core; the core's own trava is ORed with it.
REQ-012 SHALL have port mem_req  output  1  memory write request.
REQ-013 SHALL have port mem_endereco  output  TAM_ENDERECO  write address.
REQ-014 SHALL have port mem_dado  output  log2(NUM_CLUSTERS)+TAM_HASH  write data, packed {cluster, hash}.
REQ-015 SHALL have port mem_ack  input  1  memory accepted the current request.
REQ-016 SHALL have port erro_perda  output  1  sticky flag: a write was dropped.

Function
REQ-017 SHALL hold up to PROFUNDIDADE entries {endereco, hash, cluster} in FIFO order, with wrapping read/write pointers and a count of width log2(PROFUNDIDADE)+1.
REQ-018 SHALL accept a push at an edge where escrever=1 and count<PROFUNDIDADE, using the count value before that edge; no same-cycle bypass from a pop.
REQ-019 SHALL drop escrever=1 while count=PROFUNDIDADE, leave the queue unchanged, and set erro_perda=1 until reset.
REQ-020 SHALL drive trava=1 exactly when count>=PROFUNDIDADE-1, derived from registers only, with no combinational path from any input.
REQ-021 SHALL implement an FSM with states OCIOSO and ENVIA.
REQ-022 In OCIOSO with count>0, SHALL load the head entry into the mem_* output registers, set mem_req=1 and move to ENVIA at the same edge.
REQ-023 In ENVIA, SHALL hold mem_req, mem_endereco and mem_dado stable until an edge with mem_ack=1.
REQ-024 On mem_ack in ENVIA, SHALL pop the head. If count-1>0, it SHALL load the next entry and stay in ENVIA, giving back-to-back requests. Otherwise it SHALL clear mem_req and return to OCIOSO.
REQ-025 An entry pushed at the same edge as a pop SHALL NOT count toward the count-1>0 check at that edge.
REQ-026 Push and pop at the same edge SHALL leave count unchanged.
REQ-027 mem_ack while mem_req=0 SHALL be ignored.
REQ-028 Latency: a write accepted into an empty queue in OCIOSO at edge t SHALL produce mem_req=1 after edge t+1.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously set count=0, both pointers to 0, state OCIOSO, mem_req=0, mem_endereco=0, mem_dado=0, trava=0 and erro_perda=0.
REQ-030 A reset during ENVIA SHALL abandon the in-flight request and all queued entries; mem_ack after release SHALL be ignored.
REQ-031 Storage array contents SHALL NOT need reset.

Configuration
REQ-032 With FILA_ESCRITA_ESTATISTICAS_EN defined, the block SHALL add output total_escritas[31:0], counting mem_ack handshakes (wrapping at 2^32), and output ciclos_trava[31:0], counting cycles with trava=1 (saturating at 2^32-1); both reset to 0.
REQ-033 Without FILA_ESCRITA_ESTATISTICAS_EN, the block SHALL have neither port nor any counter logic.

Structure
REQ-034 The shared package pacote_hardcore SHALL hold NUM_CLUSTERS, TAM_HASH, TAM_ENDERECO, the FSM state enum, and the packed entry struct {cluster, hash, endereco}.
REQ-035 Storage SHALL be sub-module memoria_fila: a PROFUNDIDADE x entry register array with one write port, one read port and no reset.

Verification
REQ-036 Reset, then single write endereco=0x40, hash=0xA5, cluster=3 with mem_ack tied high -> mem_req high after second edge, mem_dado=0x3A5, one cycle only, then OCIOSO.
REQ-037 Four writes with mem_ack=0 -> trava=1 once count=3; a fifth write -> dropped, erro_perda=1, count stays 4.
REQ-038 Queue holds 0x00, 0x40, 0x80 and mem_ack is held high -> mem_endereco 0x00, 0x40, 0x80 on consecutive cycles with no mem_req gap.
REQ-039 Queue full, push and mem_ack at the same edge -> push dropped, erro_perda set, count=3; FIFO order preserved across pointer wrap for 10 entries.
REQ-040 rst_n low mid-ENVIA -> mem_req=0 asynchronously; a late mem_ack ignored; next write restarts at pointer 0.
REQ-041 With FILA_ESCRITA_ESTATISTICAS_EN, five acks and three trava cycles -> total_escritas=5, ciclos_trava=3.
